parity_frame_rx: RTL

Serial frame receiver with XOR parity check; the receiving end of the team's single-wire parity-protected link. It deserialises start / DATA_W data bits (LSB first) / parity / stop frames from an oversampled line, checks parity by XOR reduction and checks framing. Each frame is presented as a parallel word with error flags on a valid/ready output port.

---
 rtl/parity_frame_rx_if.sv | 19 +
 rtl/parity_frame_rx.sv | 123 ++++++++++++
 2 files changed

// File: rtl/parity_frame_rx_if.sv
// parity_frame_rx_if: parallel output port of the serial frame receiver.
//   DATA     received word, stable while VALID=1
//   VALID    DATA/PAR_ERR/FRM_ERR hold a frame
//   READY    consumer accepts; transfer on VALID & READY
//   PAR_ERR  parity mismatch for the presented frame
//   FRM_ERR  stop bit sampled low for the presented frame
// master = receiver side, slave = consumer side.
interface parity_frame_rx_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] DATA;
   logic              VALID;
   logic              READY;
   logic              PAR_ERR;
   logic              FRM_ERR;

   modport master (output DATA, VALID, PAR_ERR, FRM_ERR, input READY);
   modport slave  (input DATA, VALID, PAR_ERR, FRM_ERR, output READY);
endinterface

// File: rtl/parity_frame_rx.sv
// parity_frame_rx: oversampled serial frame receiver with XOR parity check.
// Frame: start(0) / DATA_W data bits LSB first / parity / stop(1).
// Ports:
//   CLK      system clock, rising edge
//   RST_N    asynchronous active-low reset
//   RXD      serial line, idle high, asynchronous to CLK
//   rx       parallel word + error flags, valid/ready (master side)
//   OVERRUN  one-cycle pulse when a completed frame is dropped
//   BUSY     receiver is inside a frame (FSM not idle)
module parity_frame_rx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_ODD   = 0
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                RXD,
   parity_frame_rx_if.master   rx,
   output logic                OVERRUN,
   output logic                BUSY
);
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_W + 1);
   localparam logic [TW-1:0] TICK_MID = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] TICK_END = TW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
   localparam logic          ODD      = (PARITY_ODD != 0);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t            state;
   logic              rx_s1, rx_s2;
   logic [TW-1:0]     tick;
   logic [BW-1:0]     bit_cnt;
   logic [DATA_W-1:0] shift;
   logic              par_err_q;
   logic              rxs;
   logic              tick_end;

   assign rxs      = rx_s2;
   assign tick_end = (tick == TICK_END);
   assign BUSY     = (state != S_IDLE);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         // synchroniser resets high so the idle line never looks like a start
         rx_s1      <= 1'b1;
         rx_s2      <= 1'b1;
         state      <= S_IDLE;
         tick       <= '0;
         bit_cnt    <= '0;
         shift      <= '0;
         par_err_q  <= 1'b0;
         rx.DATA    <= '0;
         rx.VALID   <= 1'b0;
         rx.PAR_ERR <= 1'b0;
         rx.FRM_ERR <= 1'b0;
         OVERRUN    <= 1'b0;
      end else begin
         rx_s1   <= RXD;
         rx_s2   <= rx_s1;
         OVERRUN <= 1'b0;
         if (rx.VALID && rx.READY) rx.VALID <= 1'b0;

         case (state)
            S_IDLE: begin
               if (!rxs) begin
                  state <= S_START;
                  tick  <= '0;
               end
            end
            S_START: begin
               // mid-bit check rejects short low glitches
               if (tick == TICK_MID) begin
                  tick    <= '0;
                  bit_cnt <= '0;
                  state   <= rxs ? S_IDLE : S_DATA;
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            S_DATA: begin
               if (tick_end) begin
                  tick <= '0;
                  for (int i = 0; i < DATA_W; i++)
                     if (bit_cnt == BW'(i)) shift[i] <= rxs;
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == BIT_LAST) state <= S_PARITY;
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            S_PARITY: begin
               if (tick_end) begin
                  tick      <= '0;
                  par_err_q <= (^shift) ^ rxs ^ ODD;
                  state     <= S_STOP;
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            S_STOP: begin
               // complete at mid-stop so a back-to-back start edge is not missed
               if (tick_end) begin
                  tick  <= '0;
                  state <= S_IDLE;
                  if (!rx.VALID || rx.READY) begin
                     rx.DATA    <= shift;
                     rx.PAR_ERR <= par_err_q;
                     rx.FRM_ERR <= ~rxs;
                     rx.VALID   <= 1'b1;
                  end else begin
                     OVERRUN <= 1'b1;
                  end
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
